dmem_responder: RTL and testbench

- Data-memory responder serving the memory-stage load/store port of the 5-stage pipeline.
- Accepts one word request per access from the M stage (address = ALU result, store data = forwarded rt value).
- Emulates a multi-cycle memory with a latency counter and holds the pipeline via stallM until the access completes.
- Returns load data on readdataM and flags misaligned or illegal requests.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_ram.sv | 32 +++
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } kind_t;

    localparam int unsigned DEF_DEPTH_WORDS = 256;
    localparam int unsigned DEF_ADDRW       = 8;
    localparam int unsigned DEF_LATENCY     = 2;
    localparam int unsigned CNTW            = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage load/store port between the pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] addrM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        errM;
    logic        busy;

    modport master (
        output memreadM, memwriteM, addrM, writedataM,
        input  readdataM, stallM, errM, busy
    );

    modport slave (
        input  memreadM, memwriteM, addrM, writedataM,
        output readdataM, stallM, errM, busy
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM; read port registered and held between reads.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDRW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [ADDRW-1:0] addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd
);

    logic [31:0] mem [DEPTH_WORDS];

    // Backing store is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= 32'h0;
        end else if (en && !we) begin
            rd <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the M stage: latches one request, stalls the
// pipeline for LATENCY cycles, then completes the access and releases for one DONE cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned ADDRW       = DEF_ADDRW,
    parameter int unsigned LATENCY     = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY - 1);
    localparam bit              SHORT    = (LATENCY == 1);

    state_t          state;
    kind_t           kind_q;
    logic [ADDRW-1:0] idx_q;
    logic [31:0]     wd_q;
    logic [CNTW-1:0] cnt;

    logic             req;
    logic             legal;
    logic             accept;
    logic             finish_busy;
    logic             ram_en;
    logic             ram_we;
    logic [ADDRW-1:0] idx_in;
    logic [ADDRW-1:0] ram_addr;
    logic [31:0]      ram_wd;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^{bus.addrM[31:ADDRW+2]};

    // Request decode, RAM port steering and combinational handshake outputs.
    always_comb begin
        req         = bus.memreadM | bus.memwriteM;
        legal       = (bus.memreadM ^ bus.memwriteM) && (bus.addrM[1:0] == 2'b00);
        idx_in      = bus.addrM[ADDRW+1:2];
        accept      = (state == IDLE) && legal;
        // Counter reaches zero on this edge: the access completes now.
        finish_busy = (state == BUSY) && (cnt == CNTW'(1));
        ram_en      = !rst && (finish_busy || (accept && SHORT));
        ram_we      = accept ? bus.memwriteM : (kind_q == KIND_WR);
        ram_addr    = accept ? idx_in : idx_q;
        ram_wd      = accept ? bus.writedataM : wd_q;
        bus.stallM  = accept || (state == BUSY);
        bus.errM    = (state == IDLE) && req && !legal;
        bus.busy    = (state == BUSY) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            kind_q <= KIND_RD;
            idx_q  <= '0;
            wd_q   <= 32'h0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        kind_q <= bus.memwriteM ? KIND_WR : KIND_RD;
                        idx_q  <= idx_in;
                        wd_q   <= bus.writedataM;
                        cnt    <= CNT_INIT;
                        state  <= SHORT ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNTW'(1);
                    if (finish_busy) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDRW       (ADDRW)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wd   (ram_wd),
        .rd   (bus.readdataM)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mr [2];
    logic        mw [2];
    logic [31:0] ad [2];
    logic [31:0] wdat [2];
    logic [31:0] rdv [2];
    logic        stl [2];
    logic        erv [2];
    logic        bsy [2];

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();

    assign if0.memreadM   = mr[0];
    assign if0.memwriteM  = mw[0];
    assign if0.addrM      = ad[0];
    assign if0.writedataM = wdat[0];
    assign rdv[0] = if0.readdataM;
    assign stl[0] = if0.stallM;
    assign erv[0] = if0.errM;
    assign bsy[0] = if0.busy;

    assign if1.memreadM   = mr[1];
    assign if1.memwriteM  = mw[1];
    assign if1.addrM      = ad[1];
    assign if1.writedataM = wdat[1];
    assign rdv[1] = if1.readdataM;
    assign stl[1] = if1.stallM;
    assign erv[1] = if1.errM;
    assign bsy[1] = if1.busy;

    dmem_responder #(.DEPTH_WORDS(256), .ADDRW(8), .LATENCY(2)) u_lat2 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    dmem_responder #(.DEPTH_WORDS(256), .ADDRW(8), .LATENCY(1)) u_lat1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    typedef struct {
        int          inst;
        bit          err;
        bit          load;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] model_mem [int];
    logic [31:0] last_load [2];
    int          stall_cnt [2];
    int          total = 0;
    int          bad   = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Word slot in the reference memory: addresses wrap modulo DEPTH_WORDS*4 bytes.
    function automatic int slot(input int i, input logic [31:0] a);
        return i * 1024 + int'((a % 32'd1024) / 32'd4);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation on every err pulse or DONE cycle.
    exp_t e;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                stall_cnt[i] = 0;
            end else begin
                if (stl[i]) stall_cnt[i]++;
                if (erv[i] || (bsy[i] && !stl[i])) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: inst %0d err=%b busy=%b with empty queue", i, erv[i], bsy[i]);
                    end else begin
                        e = sbq.pop_front();
                        check("event_inst", i, e.inst);
                        check("event_is_err", 32'(erv[i]), 32'(e.err));
                        if (erv[i]) begin
                            check("err_no_stall", 32'(stl[i]), 32'd0);
                            check("err_not_busy", 32'(bsy[i]), 32'd0);
                            check("err_rd_hold", rdv[i], last_load[i]);
                        end else begin
                            check("stall_cycles", stall_cnt[i], lat(i));
                            if (e.load) check("load_data", rdv[i], e.data);
                        end
                    end
                    if (!erv[i]) stall_cnt[i] = 0;
                end
            end
        end
    end

    // Issue one request starting at posedge+1; returns at posedge+1 after completion.
    task automatic req(input int i, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        bit   legal;
        bit   done;
        int   key;
        legal = (rd != wr) && (a[1:0] == 2'b00);
        key   = slot(i, a);
        mr[i] = rd; mw[i] = wr; ad[i] = a; wdat[i] = d;
        x.inst = i; x.err = !legal; x.load = rd && !wr; x.data = 32'h0;
        if (!legal) begin
            if (rd || wr) sbq.push_back(x);
            @(posedge clk); #1;
            mr[i] = 1'b0; mw[i] = 1'b0;
            return;
        end
        if (wr) begin
            model_mem[key] = d;
        end else begin
            x.data = model_mem.exists(key) ? model_mem[key] : 32'h0;
            last_load[i] = x.data;
        end
        sbq.push_back(x);
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bsy[i] && !stl[i]) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL access_timeout: inst %0d addr %h never reached DONE", i, a);
        end
        @(posedge clk); #1;
        mr[i] = 1'b0; mw[i] = 1'b0;
    endtask

    task automatic idle_outputs_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_stall"}, 32'(stl[i]), 32'd0);
            check({tag, "_err"},   32'(erv[i]), 32'd0);
            check({tag, "_busy"},  32'(bsy[i]), 32'd0);
            check({tag, "_rdata"}, rdv[i], 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] pool_a [4];
        int          r;
        int          i;
        for (int k = 0; k < 2; k++) begin
            mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 32'h0; wdat[k] = 32'h0;
            last_load[k] = 32'h0; stall_cnt[k] = 0;
        end

        // Reset held 3 cycles, then idle.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            idle_outputs_zero("in_reset");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            idle_outputs_zero("after_reset");
        end
        @(posedge clk); #1;

        // Store then load, LATENCY=2.
        req(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        req(0, 1'b1, 1'b0, 32'h40, 32'h0);

        // Misaligned and read+write requests.
        req(0, 1'b1, 1'b0, 32'h41, 32'h0);
        @(posedge clk); #1;
        req(0, 1'b1, 1'b1, 32'h44, 32'h0);
        @(posedge clk); #1;

        // Address aliasing across the 1 KiB window.
        req(0, 1'b0, 1'b1, 32'h400, 32'h12345678);
        req(0, 1'b1, 1'b0, 32'h000, 32'h0);

        // Reset during the first BUSY cycle aborts the pending store.
        req(0, 1'b0, 1'b1, 32'h10, 32'h11111111);
        mr[0] = 1'b0; mw[0] = 1'b1; ad[0] = 32'h10; wdat[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        mw[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_load[0] = 32'h0;
        last_load[1] = 32'h0;
        @(negedge clk);
        idle_outputs_zero("abort");
        @(posedge clk); #1;
        req(0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Back-to-back alternating stores/loads, LATENCY=1.
        pool_a[0] = 32'h0; pool_a[1] = 32'h4; pool_a[2] = 32'h3FC; pool_a[3] = 32'h80;
        for (int k = 0; k < 4; k++) begin
            req(1, 1'b0, 1'b1, pool_a[k], 32'hA5000000 + 32'(k));
            req(1, 1'b1, 1'b0, pool_a[k], 32'h0);
        end

        // Seed a small address pool on both instances so random loads hit known data.
        for (int k = 0; k < 8; k++) begin
            req(0, 1'b0, 1'b1, 32'h200 + 32'(k * 4), $urandom);
            req(1, 1'b0, 1'b1, 32'h200 + 32'(k * 4), $urandom);
        end

        // Randomized traffic with aliased upper address bits and random gaps.
        for (int n = 0; n < 120; n++) begin
            i = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            a = ($urandom & 32'hFFFF_FC00) | (32'h200 + 32'($urandom_range(0, 7)) * 32'd4);
            if (r == 0)      req(i, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0);
            else if (r == 1) req(i, 1'b1, 1'b1, a, $urandom);
            else if (r < 6)  req(i, 1'b0, 1'b1, a, $urandom);
            else             req(i, 1'b1, 1'b0, a, 32'h0);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (4) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d expected events never seen", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
